// File: rtl/moesi_pkg.sv
// Shared MOESI snoop types.
//   moesi_state_t : stored line state, I=0 S=1 E=2 O=3 M=4
//   bus_req_t     : coherency bus request type
//   snoop_fsm_t   : snoop responder FSM state, with FSM_* constants
package moesi_pkg;

    localparam int MOESI_STATE_W = 3;

    typedef enum logic [MOESI_STATE_W-1:0] {
        MOESI_I = 3'd0,
        MOESI_S = 3'd1,
        MOESI_E = 3'd2,
        MOESI_O = 3'd3,
        MOESI_M = 3'd4
    } moesi_state_t;

    typedef enum logic [1:0] {
        BUS_RD   = 2'b00,
        BUS_RDX  = 2'b01,
        BUS_UPGR = 2'b10,
        BUS_WB   = 2'b11
    } bus_req_t;

    typedef logic [1:0] snoop_fsm_t;

    localparam snoop_fsm_t FSM_IDLE    = 2'd0;
    localparam snoop_fsm_t FSM_LOOKUP  = 2'd1;
    localparam snoop_fsm_t FSM_RESPOND = 2'd2;

endpackage

// File: rtl/moesi_snoop_next.sv
// MOESI snoop transition function (combinational).
//   cur_state  in  : state of the snooped line
//   bus_type   in  : broadcast request type
//   next_state out : state after the snoop
//   dirty      out : this cache must supply the (dirty) data
//   shared     out : line stays valid alongside the requester's copy
//   illegal    out : request is inconsistent with the held state
module moesi_snoop_next
    import moesi_pkg::*;
(
    input  moesi_state_t cur_state,
    input  bus_req_t     bus_type,
    output moesi_state_t next_state,
    output logic         dirty,
    output logic         shared,
    output logic         illegal
);

    always_comb begin
        next_state = cur_state;
        dirty      = 1'b0;
        shared     = 1'b0;
        illegal    = 1'b0;
        unique case (bus_type)
            BUS_RD: begin
                case (cur_state)
                    MOESI_M: begin next_state = MOESI_O; dirty = 1'b1; end
                    MOESI_O: begin dirty = 1'b1; shared = 1'b1; end
                    MOESI_E: begin next_state = MOESI_S; shared = 1'b1; end
                    MOESI_S: shared = 1'b1;
                    default: ;
                endcase
            end
            BUS_RDX: begin
                next_state = MOESI_I;
                dirty      = (cur_state == MOESI_M) || (cur_state == MOESI_O);
            end
            BUS_UPGR: begin
                next_state = MOESI_I;
                // An upgrader claims a shared copy, which cannot coexist with E/M here.
                illegal    = (cur_state == MOESI_E) || (cur_state == MOESI_M);
            end
            default: ; // writebacks never change a snooper's state
        endcase
    end

endmodule

// File: rtl/moesi_snoop_responder.sv
// Per-core MOESI snoop responder. Watches the coherency bus broadcast, looks
// the address up in this core's L1 tag/state array and applies the snoop
// transition. IDLE -> LOOKUP -> RESPOND -> IDLE.
//   bus_*            : broadcast strobe, address, type, requester id
//   tag_rd_*         : tag/state array read (1-cycle latency)
//   st_wr_*          : state write-back
//   snoop_busy       : core pipeline must keep off the tag array
//   snoop_resp/dirty/shared : single-cycle hit response and qualifiers
//   snoop_err        : sticky protocol error
module moesi_snoop_responder
    import moesi_pkg::*;
#(
    parameter int unsigned NUM_CORES        = 4,
    parameter int unsigned ADDR_WIDTH       = 64,
    parameter int unsigned CORE_ID          = 0,
    parameter int unsigned LINE_OFFSET_BITS = 6,
    parameter int unsigned INDEX_BITS       = 6,
    localparam int unsigned TAG_WIDTH       = ADDR_WIDTH - LINE_OFFSET_BITS - INDEX_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bus_valid,
    input  logic [ADDR_WIDTH-1:0]    bus_addr,
    input  logic [1:0]               bus_type,
    input  logic [1:0]               granted_core_id,
    output logic                     tag_rd_en,
    output logic [INDEX_BITS-1:0]    tag_rd_index,
    input  logic [TAG_WIDTH-1:0]     tag_rd_tag,
    input  logic [MOESI_STATE_W-1:0] tag_rd_state,
    output logic                     st_wr_en,
    output logic [INDEX_BITS-1:0]    st_wr_index,
    output logic [MOESI_STATE_W-1:0] st_wr_state,
    output logic                     snoop_busy,
    output logic                     snoop_resp,
    output logic                     snoop_dirty,
    output logic                     snoop_shared,
    output logic                     snoop_err
);

    if (CORE_ID >= NUM_CORES) begin : g_bad_core_id
        $error("CORE_ID out of range");
    end

    localparam logic [1:0] SELF_ID = CORE_ID[1:0];

    snoop_fsm_t             state_q, state_d;
    logic [INDEX_BITS-1:0]  cap_index_q;
    logic [TAG_WIDTH-1:0]   cap_tag_q;
    bus_req_t               cap_type_q;
    logic                   err_q, err_d;
    logic                   capture;

    // Byte offset is irrelevant to a line-granular lookup.
    logic unused_offset;
    assign unused_offset = ^bus_addr[LINE_OFFSET_BITS-1:0];

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            FSM_IDLE: begin
                if (bus_valid && (granted_core_id != SELF_ID) &&
                    (bus_req_t'(bus_type) != BUS_WB)) begin
                    capture = 1'b1;
                    state_d = FSM_LOOKUP;
                end
            end
            FSM_LOOKUP:  state_d = FSM_RESPOND;
            FSM_RESPOND: state_d = FSM_IDLE;
            default:     state_d = FSM_IDLE;
        endcase
    end

    // Lookup result evaluation (only meaningful in RESPOND).
    moesi_state_t cur_state, nx_state;
    logic         nx_dirty, nx_shared, nx_illegal;
    logic         in_lookup, in_respond, line_valid, hit;

    assign cur_state  = moesi_state_t'(tag_rd_state);
    assign in_lookup  = (state_q == FSM_LOOKUP);
    assign in_respond = (state_q == FSM_RESPOND);
    assign line_valid = cur_state inside {MOESI_S, MOESI_E, MOESI_O, MOESI_M};
    assign hit        = in_respond && (tag_rd_tag == cap_tag_q) && line_valid;

    moesi_snoop_next u_next (
        .cur_state  (cur_state),
        .bus_type   (cap_type_q),
        .next_state (nx_state),
        .dirty      (nx_dirty),
        .shared     (nx_shared),
        .illegal    (nx_illegal)
    );

    // A second broadcast inside the 3-cycle window is dropped but flagged.
    assign err_d = err_q || (bus_valid && (state_q != FSM_IDLE)) || (hit && nx_illegal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FSM_IDLE;
            cap_index_q <= '0;
            cap_tag_q   <= '0;
            cap_type_q  <= BUS_RD;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (capture) begin
                cap_index_q <= bus_addr[LINE_OFFSET_BITS +: INDEX_BITS];
                cap_tag_q   <= bus_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                cap_type_q  <= bus_req_t'(bus_type);
            end
        end
    end

    assign tag_rd_en    = in_lookup;
    assign tag_rd_index = cap_index_q;
    assign snoop_busy   = in_lookup || in_respond;
    assign snoop_resp   = hit;
    assign snoop_dirty  = hit && nx_dirty;
    assign snoop_shared = hit && nx_shared;
    assign st_wr_en     = hit && (nx_state != cur_state);
    assign st_wr_index  = cap_index_q;
    assign st_wr_state  = st_wr_en ? nx_state : MOESI_I;
    assign snoop_err    = err_q;

endmodule

// File: tb/tb_moesi_snoop_responder.sv
// Directed bench for moesi_snoop_responder (CORE_ID=1) with a small
// 1-cycle-latency tag/state array model.
module tb_moesi_snoop_responder;
    import moesi_pkg::*;

    localparam int AW = 64;
    localparam int IW = 6;
    localparam int TW = 52;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bus_valid;
    logic [AW-1:0] bus_addr;
    logic [1:0]    bus_type;
    logic [1:0]    granted_core_id;
    logic          tag_rd_en;
    logic [IW-1:0] tag_rd_index;
    logic [TW-1:0] tag_rd_tag;
    logic [2:0]    tag_rd_state;
    logic          st_wr_en;
    logic [IW-1:0] st_wr_index;
    logic [2:0]    st_wr_state;
    logic          snoop_busy, snoop_resp, snoop_dirty, snoop_shared, snoop_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    moesi_snoop_responder #(
        .NUM_CORES        (4),
        .ADDR_WIDTH       (AW),
        .CORE_ID          (1),
        .LINE_OFFSET_BITS (6),
        .INDEX_BITS       (IW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus_valid       (bus_valid),
        .bus_addr        (bus_addr),
        .bus_type        (bus_type),
        .granted_core_id (granted_core_id),
        .tag_rd_en       (tag_rd_en),
        .tag_rd_index    (tag_rd_index),
        .tag_rd_tag      (tag_rd_tag),
        .tag_rd_state    (tag_rd_state),
        .st_wr_en        (st_wr_en),
        .st_wr_index     (st_wr_index),
        .st_wr_state     (st_wr_state),
        .snoop_busy      (snoop_busy),
        .snoop_resp      (snoop_resp),
        .snoop_dirty     (snoop_dirty),
        .snoop_shared    (snoop_shared),
        .snoop_err       (snoop_err)
    );

    // Tag/state array model; preload port driven by the stimulus.
    logic [TW-1:0] mem_tag [64];
    logic [2:0]    mem_st  [64];
    logic          pre_en;
    logic [IW-1:0] pre_idx;
    logic [TW-1:0] pre_tag;
    logic [2:0]    pre_st;

    always @(posedge clk) begin
        if (pre_en) begin
            mem_tag[pre_idx] <= pre_tag;
            mem_st[pre_idx]  <= pre_st;
        end
        if (st_wr_en) mem_st[st_wr_index] <= st_wr_state;
        if (tag_rd_en) begin
            tag_rd_tag   <= mem_tag[tag_rd_index];
            tag_rd_state <= mem_st[tag_rd_index];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_line(input logic [AW-1:0] addr, input logic [2:0] st);
        pre_en  = 1'b1;
        pre_idx = addr[11:6];
        pre_tag = addr[63:12];
        pre_st  = st;
        tick();
        pre_en  = 1'b0;
    endtask

    // exp_shared < 0 means the shared qualifier is not checked.
    task automatic run_snoop(input string nm, input logic [1:0] typ, input logic [AW-1:0] addr,
                             input logic [1:0] core, input logic exp_lookup,
                             input logic exp_resp, input logic exp_dirty, input int exp_shared,
                             input logic exp_wr, input logic [2:0] exp_st, input logic exp_err);
        bus_valid       = 1'b1;
        bus_addr        = addr;
        bus_type        = typ;
        granted_core_id = core;
        tick();
        // Scramble the bus: only the strobe cycle may be sampled.
        bus_valid = 1'b0;
        bus_addr  = ~addr;
        bus_type  = 2'b10;
        check_eq({nm, "/t1_rd_en"}, 64'(tag_rd_en), 64'(exp_lookup));
        check_eq({nm, "/t1_busy"}, 64'(snoop_busy), 64'(exp_lookup));
        check_eq({nm, "/t1_resp"}, 64'(snoop_resp), 64'(0));
        if (exp_lookup) check_eq({nm, "/t1_index"}, 64'(tag_rd_index), 64'(addr[11:6]));
        tick();
        check_eq({nm, "/t2_busy"}, 64'(snoop_busy), 64'(exp_lookup));
        check_eq({nm, "/t2_resp"}, 64'(snoop_resp), 64'(exp_resp));
        check_eq({nm, "/t2_dirty"}, 64'(snoop_dirty), 64'(exp_dirty));
        if (exp_shared >= 0) check_eq({nm, "/t2_shared"}, 64'(snoop_shared), 64'(exp_shared));
        check_eq({nm, "/t2_wr_en"}, 64'(st_wr_en), 64'(exp_wr));
        if (exp_wr) begin
            check_eq({nm, "/t2_wr_state"}, 64'(st_wr_state), 64'(exp_st));
            check_eq({nm, "/t2_wr_index"}, 64'(st_wr_index), 64'(addr[11:6]));
        end
        tick();
        check_eq({nm, "/t3_busy"}, 64'(snoop_busy), 64'(0));
        check_eq({nm, "/t3_resp"}, 64'(snoop_resp), 64'(0));
        check_eq({nm, "/t3_err"}, 64'(snoop_err), 64'(exp_err));
    endtask

    task automatic check_quiet(input string nm);
        check_eq({nm, "/rd_en"}, 64'(tag_rd_en), 64'(0));
        check_eq({nm, "/busy"}, 64'(snoop_busy), 64'(0));
        check_eq({nm, "/resp"}, 64'(snoop_resp), 64'(0));
        check_eq({nm, "/wr_en"}, 64'(st_wr_en), 64'(0));
        check_eq({nm, "/err"}, 64'(snoop_err), 64'(0));
    endtask

    initial begin
        rst_n           = 1'b0;
        bus_valid       = 1'b0;
        bus_addr        = '0;
        bus_type        = 2'b00;
        granted_core_id = 2'd0;
        pre_en          = 1'b0;
        pre_idx         = '0;
        pre_tag         = '0;
        pre_st          = '0;
        #1;
        check_quiet("reset");
        check_eq("reset/dirty", 64'(snoop_dirty), 64'(0));
        check_eq("reset/shared", 64'(snoop_shared), 64'(0));
        check_eq("reset/wr_state", 64'(st_wr_state), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;

        // M line, RD from core 0 -> O, dirty.
        load_line(64'h1000, 3'd4);
        run_snoop("rd_m", 2'b00, 64'h1000, 2'd0, 1, 1, 1, -1, 1, 3'd3, 0);
        // Now O, RD from core 2 -> stays O, dirty + shared, no write.
        run_snoop("rd_o", 2'b00, 64'h1000, 2'd2, 1, 1, 1, 1, 0, 3'd0, 0);
        // E line, RDX from core 2 -> I, clean.
        load_line(64'h2040, 3'd2);
        run_snoop("rdx_e", 2'b01, 64'h2040, 2'd2, 1, 1, 0, 0, 1, 3'd0, 0);
        // Same line is now I -> miss.
        run_snoop("rd_inv", 2'b00, 64'h2040, 2'd0, 1, 0, 0, 0, 0, 3'd0, 0);
        // Self-snoop and writeback are ignored.
        run_snoop("self", 2'b00, 64'h3000, 2'd1, 0, 0, 0, 0, 0, 3'd0, 0);
        run_snoop("wb", 2'b11, 64'h1000, 2'd0, 0, 0, 0, 0, 0, 3'd0, 0);
        // S line tag 0x5000, probe 0x4000 at the same index -> miss.
        load_line(64'h5000, 3'd1);
        run_snoop("tag_miss", 2'b00, 64'h4000, 2'd0, 1, 0, 0, 0, 0, 3'd0, 0);
        run_snoop("rd_s", 2'b00, 64'h5000, 2'd3, 1, 1, 0, 1, 0, 3'd0, 0);
        // UPGR against M is illegal: invalidate and raise the sticky error.
        load_line(64'h6080, 3'd4);
        run_snoop("upgr_m", 2'b10, 64'h6080, 2'd3, 1, 1, 0, 0, 1, 3'd0, 1);
        // Clean E->S snoop afterwards; error stays set.
        load_line(64'h70C0, 3'd2);
        run_snoop("rd_e", 2'b00, 64'h70C0, 2'd0, 1, 1, 0, 1, 1, 3'd1, 1);

        // Reset clears the error.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("rst2/err", 64'(snoop_err), 64'(0));

        // Back-to-back broadcasts: second dropped, error flagged.
        load_line(64'h8100, 3'd1);
        bus_valid       = 1'b1;
        bus_addr        = 64'h8100;
        bus_type        = 2'b00;
        granted_core_id = 2'd0;
        tick();
        check_eq("b2b/t1_rd_en", 64'(tag_rd_en), 64'(1));
        bus_type        = 2'b01;
        granted_core_id = 2'd2;
        tick();
        bus_valid = 1'b0;
        check_eq("b2b/t2_resp", 64'(snoop_resp), 64'(1));
        check_eq("b2b/t2_shared", 64'(snoop_shared), 64'(1));
        check_eq("b2b/t2_dirty", 64'(snoop_dirty), 64'(0));
        check_eq("b2b/t2_wr_en", 64'(st_wr_en), 64'(0));
        check_eq("b2b/t2_err", 64'(snoop_err), 64'(1));
        tick();
        check_eq("b2b/t3_busy", 64'(snoop_busy), 64'(0));
        check_eq("b2b/t3_rd_en", 64'(tag_rd_en), 64'(0));
        tick();
        check_eq("b2b/t4_rd_en", 64'(tag_rd_en), 64'(0));
        check_eq("b2b/t4_err", 64'(snoop_err), 64'(1));

        // Reset in the LOOKUP cycle of an RDX to an M line: no write.
        load_line(64'h9140, 3'd4);
        bus_valid       = 1'b1;
        bus_addr        = 64'h9140;
        bus_type        = 2'b01;
        granted_core_id = 2'd0;
        tick();
        bus_valid = 1'b0;
        check_eq("mid_rst/t1_rd_en", 64'(tag_rd_en), 64'(1));
        rst_n = 1'b0;
        #1;
        check_quiet("mid_rst/now");
        tick();
        check_eq("mid_rst/t2_wr_en", 64'(st_wr_en), 64'(0));
        tick();
        check_eq("mid_rst/t3_wr_en", 64'(st_wr_en), 64'(0));
        check_eq("mid_rst/line_state", 64'(mem_st[5]), 64'(4));
        rst_n = 1'b1;
        tick();
        check_quiet("mid_rst/after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/moesi_snoop_responder.md
# moesi_snoop_responder

Per-core snoop responder: the receiving end of the coherency bus broadcast. One instance per core watches the shared bus and looks up the broadcast address in that core's L1 tag/state array. It applies the MOESI snoop transition, writes back any state change, and drives this core's bit of `snoop_resp` to the bus, plus dirty/shared qualifiers for the future data-supply path.

## Interface
Parameters:
- `NUM_CORES`, 4, number of cores on the bus
- `ADDR_WIDTH`, 64, bus address width
- `CORE_ID`, 0, this core's index; 2-bit value
- `LINE_OFFSET_BITS`, 6, byte offset within a line
- `INDEX_BITS`, 6, L1 set index width
- localparam `TAG_WIDTH` = `ADDR_WIDTH - LINE_OFFSET_BITS - INDEX_BITS`

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low. Port names `clk` and `rst_n`.
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `bus_valid`  in  1  one-cycle broadcast strobe
- `bus_addr`  in  ADDR_WIDTH  broadcast address
- `bus_type`  in  2  00 BUS_RD, 01 BUS_RDX, 10 BUS_UPGR, 11 BUS_WB
- `granted_core_id`  in  2  requester of the current broadcast
- `tag_rd_en`  out  1  tag/state array read strobe
- `tag_rd_index`  out  INDEX_BITS  read set index
- `tag_rd_tag`  in  TAG_WIDTH  stored tag, valid 1 cycle after `tag_rd_en`
- `tag_rd_state`  in  3  stored MOESI state, same timing; I=0, S=1, E=2, O=3, M=4
- `st_wr_en`  out  1  state write strobe
- `st_wr_index`  out  INDEX_BITS  write set index
- `st_wr_state`  out  3  new MOESI state
- `snoop_busy`  out  1  core pipeline must not access the tag array this cycle
- `snoop_resp`  out  1  hit pulse; this core's bit of the bus `snoop_resp` vector
- `snoop_dirty`  out  1  hit line was M/O on RD/RDX; this core supplies data
- `snoop_shared`  out  1  line remains valid (S/O) after an RD hit
- `snoop_err`  out  1  sticky protocol error

## Operation
- FSM `IDLE -> LOOKUP -> RESPOND -> IDLE`.
- **IDLE:**
  - On `bus_valid`, if `granted_core_id != CORE_ID` and `bus_type != BUS_WB`, register the index, tag and type, then go to LOOKUP.
  - Otherwise remain in IDLE with no response (self-snoop and writebacks are ignored).
- **LOOKUP:** `tag_rd_en=1`, `tag_rd_index` = captured index, `snoop_busy=1`.
- **RESPOND:**
  - `snoop_busy=1`.
  - hit = (`tag_rd_tag` == captured tag) and (`tag_rd_state` != I).
  - On hit, pulse `snoop_resp` and apply the transition below.
  - `st_wr_en=1` only when next state != current state.
- Transitions:
  - BUS_RD: M->O (dirty); O->O (dirty, shared); E->S (shared); S->S (shared).
  - BUS_RDX: M/O -> I (dirty); E/S -> I.
  - BUS_UPGR: S/O -> I. E or M -> I and set `snoop_err`, because another core cannot hold a shared copy.
  - Miss: no output pulses, no write.
- `snoop_resp`, `snoop_dirty`, `snoop_shared`, `st_wr_en` are single-cycle pulses in RESPOND only.
- `snoop_err` is sticky until reset. It is also set when `bus_valid` arrives outside IDLE; that broadcast is dropped and the in-flight snoop completes normally.

## Timing
- Reset: FSM IDLE; every output 0, including `snoop_err`; captured registers cleared.
- `bus_valid` in cycle t -> `tag_rd_en` in t+1 -> `snoop_resp`/`st_wr_en` in t+2. Back in IDLE at t+3, which matches the bus's minimum 3-cycle broadcast spacing.
- `snoop_busy` is high in t+1 and t+2.
- Tag array read latency is fixed at 1 cycle; no ready handshake.
- A state write in t+2 is visible to a tag read in t+3 or later (write-before-read not required within a cycle).
- Reset asserted mid-snoop: immediate return to IDLE, no write issued, outputs 0.
- `bus_addr` and `bus_type` are sampled only in the `bus_valid` cycle; later changes have no effect.

## Structure
- Package `moesi_pkg`:
  - `moesi_state_t` (3-bit enum, encodings above)
  - `bus_req_t` (2-bit enum)
  - `MOESI_STATE_W=3`
  - `snoop_fsm_t`
- Sub-module `moesi_snoop_next`: purely combinational. Inputs are current state and `bus_type`; outputs are next state, dirty, shared and illegal. It is reusable by the core-side cache controller's checker.
- Top module contains the FSM, the capture registers and the error flag.

## Test plan
- CORE_ID=1, line 0x1000 in M; core 0 issues BUS_RD 0x1000 -> `snoop_resp`=1, `snoop_dirty`=1, `st_wr_state`=O, all at t+2.
- Line 0x2040 in E; BUS_RDX 0x2040 from core 2 -> resp=1, dirty=0, write I; repeating the RD then misses, with no resp.
- BUS_RD 0x3000 from core 1, CORE_ID=1 (self) -> `tag_rd_en` never asserted, all outputs stay 0.
- Line in S, tag mismatch (0x4000 vs stored 0x5000, same index) -> lookup occurs, no resp, no write.
- Line in M, BUS_UPGR from core 3 -> write I, `snoop_err`=1 and held through a subsequent clean snoop.
- `bus_valid` at t and t+1 -> first snoop completes at t+2, second dropped, `snoop_err`=1. Reset at t+1 of a new snoop -> no `st_wr_en`, `snoop_err` cleared.
